// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin wormhole arbiter sharing one output port among N input buffers.
// Define ARB_LOCK_TIMEOUT_EN to force release of an owner that stalls TIMEOUT cycles while locked.
module output_port_arbiter #(
  parameter int N       = 4,
  parameter int FLIT_W  = 17,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req_i,
  input  logic [N*FLIT_W-1:0] flit_i,
  input  logic                out_ready_i,
  output logic [N-1:0]        send_o,
  output logic [FLIT_W-1:0]   data_o,
  output logic                lock_o,
  output logic                err_o
);
  localparam int PW = $clog2(N);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] rr_q, rr_d, owner_q, owner_d, g, idx, sel;
  logic err_d, found, bad, xfer, tmo;
  logic [N-1:0] elig;
  logic [FLIT_W-1:0] flit [N];
  logic [FLIT_W-1:0] sel_flit;
  logic [1:0] typ;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] x);
    return (int'(x) == N - 1) ? '0 : x + PW'(1);
  endfunction
  // Type bit 14 set marks a packet opener (head or single); only those may win in IDLE.
  always_comb begin
    g = '0;
    idx = '0;
    found = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < N; k++) begin
      flit[k] = flit_i[k*FLIT_W +: FLIT_W];
      elig[k] = req_i[k] & flit[k][FLIT_W-1];
      bad = bad | (elig[k] & ~flit[k][FLIT_W-3]);
    end
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(rr_q) + i) % N);
      if (!found && elig[idx] && flit[idx][FLIT_W-3]) begin
        g = idx;
        found = 1'b1;
      end
    end
  end
  assign sel      = (state_q == IDLE) ? g : owner_q;
  assign sel_flit = flit[sel];
  assign typ      = sel_flit[FLIT_W-2 -: 2];
  assign send_o   = (rst && out_ready_i && ((state_q == IDLE) ? found : elig[owner_q])) ? N'(1) << sel : '0;
  assign xfer     = |send_o;
  assign lock_o   = state_q == LOCKED;
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    owner_d = owner_q;
    err_d = err_o;
    if (state_q == IDLE) begin
      err_d = err_o | (bad & out_ready_i);
      if (xfer && typ == 2'b11) rr_d = inc(g);
      if (xfer && typ == 2'b01) begin
        state_d = LOCKED;
        owner_d = g;
      end
    end else begin
      err_d = err_o | (xfer & typ[0]) | tmo;
      if ((xfer && typ == 2'b10) || tmo) begin
        state_d = IDLE;
        rr_d = inc(owner_q);
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q <= '0;
      owner_q <= '0;
      data_o <= '0;
      err_o <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      owner_q <= owner_d;
      data_o <= xfer ? sel_flit : '0;
      err_o <= err_d;
    end
  end
`ifdef ARB_LOCK_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] stall_q;
  logic stall;
  assign stall = state_q == LOCKED && !elig[owner_q] && out_ready_i;
  assign tmo   = stall && stall_q == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else stall_q <= (xfer || tmo || state_q == IDLE) ? '0 : stall ? stall_q + CW'(1) : stall_q;
  end
`else
  // Without the timeout a locked owner is never released early.
  assign tmo = TIMEOUT < 0;
`endif
endmodule
